// File: rtl/pipe_bridge_if.sv
// Valid/ready word channel carrying a control field, a data field and a kill
// (bubble) qualifier; the kill line is only meaningful on the upstream side.
interface pipe_bridge_if #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic              kill;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, kill, ctrl, data, input ready);
  modport slave  (input valid, kill, ctrl, data, output ready);
endinterface

// File: rtl/pipe_bridge.sv
// Two-entry (main + skid) fully registered pipeline bridge with kill-to-bubble,
// flush, occupancy and saturating stall/bubble counters.
module pipe_bridge #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_bridge_if.slave     up,
  pipe_bridge_if.master    dn,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic              main_valid_reg, main_valid_next;
  logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg,  main_data_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
  logic              ready_reg,      ready_next;
  logic [1:0]        occupancy_reg,  occupancy_next;

  logic              accept;
  logic              deliver;
  logic [CTRL_W-1:0] in_ctrl;

  assign accept  = up.valid & ready_reg;
  assign deliver = main_valid_reg & dn.ready;
  assign in_ctrl = up.kill ? '0 : up.ctrl;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_data_next  = skid_data_reg;

    if (flush) begin
      // Data fields are deliberately kept; only valid and ctrl are squashed.
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
      skid_valid_next = 1'b0;
      skid_ctrl_next  = '0;
    end else if (deliver) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = skid_ctrl_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = in_ctrl;
        main_data_next  = up.data;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_reg) begin
        skid_valid_next = 1'b1;
        skid_ctrl_next  = in_ctrl;
        skid_data_next  = up.data;
      end else begin
        main_valid_next = 1'b1;
        main_ctrl_next  = in_ctrl;
        main_data_next  = up.data;
      end
    end

    // Accept is only possible with an empty skid, so skid never overflows.
    ready_next     = ~skid_valid_next;
    occupancy_next = {1'b0, main_valid_next} + {1'b0, skid_valid_next};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= '0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b0;
      occupancy_reg  <= 2'd0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= ready_next;
      occupancy_reg  <= occupancy_next;
    end
  end

  // Event 0: downstream stall; event 1: a zero-ctrl word handed downstream.
  logic [1:0]       cnt_event;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_event[0] = main_valid_reg & ~dn.ready;
  assign cnt_event[1] = deliver & (main_ctrl_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign up.ready   = ready_reg;
  assign dn.valid   = main_valid_reg;
  assign dn.ctrl    = main_ctrl_reg;
  assign dn.data    = main_data_reg;
  assign dn.kill    = 1'b0;
  assign occupancy  = occupancy_reg;
  assign stall_cnt  = cnt_val[0];
  assign bubble_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_bridge.sv
// Table-driven bench for pipe_bridge with an in-order scoreboard on the
// downstream side and hand sequences for saturation, flush and reset.
module tb_pipe_bridge;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;

  pipe_bridge_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
  pipe_bridge_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

  pipe_bridge #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up_if),
    .dn         (dn_if),
    .flush      (flush),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {ctrl,data} queued on accept, compared on deliver.
  logic [CW+DW-1:0] sbq[$];
  logic [CW+DW-1:0] sb_exp;

  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
    end else begin
      if (dn_if.valid && dn_if.ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got ctrl=0x%0h data=0x%0h expected no word", dn_if.ctrl, dn_if.data);
        end else begin
          sb_exp = sbq.pop_front();
          check("sb_ctrl", 32'(dn_if.ctrl), 32'(sb_exp[CW+DW-1:DW]));
          check("sb_data", 32'(dn_if.data), 32'(sb_exp[DW-1:0]));
        end
      end
      if (flush)
        sbq.delete();
      else if (up_if.valid && up_if.ready)
        sbq.push_back({(up_if.kill ? {CW{1'b0}} : up_if.ctrl), up_if.data});
    end
  end

  typedef struct {
    logic          iv, kill, fl, ordy;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          ov, ir;
    logic [1:0]    occ;
    logic          chk;
    logic [CW-1:0] octrl;
    logic [DW-1:0] odata;
    logic [NW-1:0] stall, bub;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic k, input logic fl, input logic ordy,
                              input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic ov, input logic ir, input logic [1:0] occ,
                              input logic chk, input logic [CW-1:0] oc, input logic [DW-1:0] od,
                              input logic [NW-1:0] st, input logic [NW-1:0] bu);
    vec_t v;
    v.iv = iv; v.kill = k; v.fl = fl; v.ordy = ordy; v.ctrl = c; v.data = d;
    v.ov = ov; v.ir = ir; v.occ = occ; v.chk = chk; v.octrl = oc; v.odata = od;
    v.stall = st; v.bub = bu;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic k, input logic fl, input logic ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_if.valid = iv;
    up_if.kill  = k;
    flush       = fl;
    dn_if.ready = ordy;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b1, 8'h05,16'h0011, 1'b1,1'b1,2'd1,1'b1,8'h05,16'h0011,4'd0,4'd0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,1'b1, 8'h00,16'h0000, 1'b0,1'b1,2'd0,1'b0,8'h00,16'h0000,4'd0,4'd0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0, 8'h05,16'h0011, 1'b1,1'b1,2'd1,1'b1,8'h05,16'h0011,4'd0,4'd0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0, 8'h0a,16'h0022, 1'b1,1'b0,2'd2,1'b1,8'h05,16'h0011,4'd1,4'd0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0, 8'hee,16'h00ee, 1'b1,1'b0,2'd2,1'b1,8'h05,16'h0011,4'd2,4'd0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b1, 8'h00,16'h0000, 1'b1,1'b1,2'd1,1'b1,8'h0a,16'h0022,4'd2,4'd0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b1, 8'h00,16'h0000, 1'b0,1'b1,2'd0,1'b0,8'h00,16'h0000,4'd2,4'd0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b1, 8'h07,16'h0033, 1'b1,1'b1,2'd1,1'b1,8'h00,16'h0033,4'd2,4'd0);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b1, 8'h00,16'h0000, 1'b0,1'b1,2'd0,1'b0,8'h00,16'h0000,4'd2,4'd1);
    vecs[9]  = mk(1'b0,1'b1,1'b0,1'b1, 8'h55,16'h0abc, 1'b0,1'b1,2'd0,1'b0,8'h00,16'h0000,4'd2,4'd1);
    vecs[10] = mk(1'b1,1'b0,1'b0,1'b1, 8'h11,16'h0044, 1'b1,1'b1,2'd1,1'b1,8'h11,16'h0044,4'd2,4'd1);
    vecs[11] = mk(1'b1,1'b0,1'b0,1'b1, 8'h12,16'h0055, 1'b1,1'b1,2'd1,1'b1,8'h12,16'h0055,4'd2,4'd1);
    vecs[12] = mk(1'b1,1'b0,1'b0,1'b0, 8'h13,16'h0066, 1'b1,1'b0,2'd2,1'b1,8'h12,16'h0055,4'd3,4'd1);
    vecs[13] = mk(1'b1,1'b0,1'b1,1'b0, 8'h14,16'h0077, 1'b0,1'b1,2'd0,1'b1,8'h00,16'h0055,4'd4,4'd1);
    vecs[14] = mk(1'b1,1'b0,1'b0,1'b1, 8'h15,16'h0088, 1'b1,1'b1,2'd1,1'b1,8'h15,16'h0088,4'd4,4'd1);
    vecs[15] = mk(1'b1,1'b0,1'b1,1'b0, 8'h16,16'h0099, 1'b0,1'b1,2'd0,1'b1,8'h00,16'h0088,4'd5,4'd1);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b1, 8'h00,16'h0000, 1'b0,1'b1,2'd0,1'b0,8'h00,16'h0000,4'd5,4'd1);

    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    step();
    step();
    check("rst_out_valid", 32'(dn_if.valid), 32'd0);
    check("rst_in_ready",  32'(up_if.ready), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_ctrl",  32'(dn_if.ctrl), 32'd0);
    check("rst_out_data",  32'(dn_if.data), 32'd0);
    check("rst_stall",     32'(stall_cnt), 32'd0);
    check("rst_bubble",    32'(bubble_cnt), 32'd0);
    rst = 1'b1;
    step();
    check("rel_in_ready", 32'(up_if.ready), 32'd1);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].kill, vecs[i].fl, vecs[i].ordy, vecs[i].ctrl, vecs[i].data);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(dn_if.valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_in_ready", i),  32'(up_if.ready), 32'(vecs[i].ir));
      check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      check($sformatf("v%0d_stall", i),     32'(stall_cnt), 32'(vecs[i].stall));
      check($sformatf("v%0d_bubble", i),    32'(bubble_cnt), 32'(vecs[i].bub));
      if (vecs[i].chk) begin
        check($sformatf("v%0d_out_ctrl", i), 32'(dn_if.ctrl), 32'(vecs[i].octrl));
        check($sformatf("v%0d_out_data", i), 32'(dn_if.data), 32'(vecs[i].odata));
      end
    end

    // Stall counter saturation, then reset with two words stored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 16'h0101);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 20; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'd15);
    step();
    check("stall_hold", 32'(stall_cnt), 32'd15);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h32, 16'h0202);
    step();
    check("full_occupancy", 32'(occupancy), 32'd2);
    check("full_in_ready",  32'(up_if.ready), 32'd0);
    check("full_out_data",  32'(dn_if.data), 32'h0101);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 16'h0303);
    step();
    check("mid_rst_out_valid", 32'(dn_if.valid), 32'd0);
    check("mid_rst_in_ready",  32'(up_if.ready), 32'd0);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    check("mid_rst_out_ctrl",  32'(dn_if.ctrl), 32'd0);
    check("mid_rst_out_data",  32'(dn_if.data), 32'd0);
    check("mid_rst_stall",     32'(stall_cnt), 32'd0);
    check("mid_rst_bubble",    32'(bubble_cnt), 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
    step();
    check("mid_rel_in_ready",  32'(up_if.ready), 32'd1);
    check("mid_rel_occupancy", 32'(occupancy), 32'd0);

    // Back-to-back killed words: full throughput, bubble counter saturates
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40 + 8'(i), 16'h1000 + 16'(i));
      step();
      check($sformatf("tp%0d_occupancy", i), 32'(occupancy), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
    step();
    check("bubble_sat",     32'(bubble_cnt), 32'd15);
    check("tp_stall_zero",  32'(stall_cnt), 32'd0);
    check("tp_drained",     32'(dn_if.valid), 32'd0);
    step();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
